writeback_forward_unit: RTL and testbench
=========================================

Name: writeback_forward_unit

Overview:
- Producer side of the dual-port register-file write interface: takes results from the even and odd execution pipes and supplies each write port's data, address and write enable.
- Each pipe result enters a per-pipe result shift pipeline at a depth equal to its unit latency, advances one stage per cycle, and issues its register write from the final stage.
- Also forwards in-flight results to the five operand read ports, so decode sees the newest value before it is written back.

Parameters:
- QUADWORD, 128, register/result width in bits
- REG_ADDR_WIDTH, 7, register address width
- WB_DEPTH, 7, number of result stages per pipe; the last stage drives the write
- LAT_WIDTH, 3, width of latency tag; must hold WB_DEPTH

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-high reset
- ev_result / od_result  in  QUADWORD  unit result, even/odd pipe
- ev_addr / od_addr  in  REG_ADDR_WIDTH  destination register
- ev_valid / od_valid  in  1  result present this cycle
- ev_lat / od_lat  in  LAT_WIDTH  target stage 1..WB_DEPTH
- rf_ra_ev, rf_rb_ev, rf_rc_ev, rf_ra_od, rf_rb_od  in  QUADWORD  raw register-file read data
- addr_ra_ev, addr_rb_ev, addr_rc_ev, addr_ra_od, addr_rb_od  in  REG_ADDR_WIDTH  read addresses, same as fed to the register file
- fw_ra_ev, fw_rb_ev, fw_rc_ev, fw_ra_od, fw_rb_od  out  QUADWORD  forwarded operands
- rt_wt_even / rt_wt_odd  out  QUADWORD  write data
- addr_rt_wt_even / addr_rt_wt_odd  out  REG_ADDR_WIDTH  write address
- regWr_en_even / regWr_en_odd  out  1  write enable
- lat_err  out  1  sticky: latency out of range
- collide_err  out  1  sticky: stage collision

Behaviour:
- Storage: per pipe, stages 1..WB_DEPTH, each holding {valid, addr, data}.
- Each posedge: stage k+1 <= stage k for k = 1..WB_DEPTH-1. Stage 1 <= empty unless an insertion targets it.
- Insertion: valid input with lat L in 1..WB_DEPTH is written into stage L at the same edge. The result reaches stage WB_DEPTH after WB_DEPTH-L further edges.
- lat = 0 or lat > WB_DEPTH: input is dropped and lat_err is set.
- Collision: insertion targets stage L while stage L-1 (L>1) is valid and shifting in. The new input wins, the shifted entry is lost, and collide_err is set. Issue logic must prevent this case.
- Write outputs are driven directly from stage WB_DEPTH, so they are registered. regWr_en_x = stage[WB_DEPTH].valid.
- Latency: an input with lat L produces its regWr_en pulse WB_DEPTH-L+1 cycles after the input cycle (lat = WB_DEPTH gives the next cycle).
- Forwarding is combinational. For each read address, compare against all valid stages of both pipes.
  - The lowest-numbered (youngest) matching stage wins.
  - On a same-stage tie between even and odd, odd wins.
  - With no match, output the raw rf_* value.
  - Stage WB_DEPTH participates, because its write lands only at the next edge.
- Simultaneous regWr_en_even and regWr_en_odd to the same address is passed through unchanged; resolving it belongs to the register file.
- Reset: all valid bits cleared asynchronously; rt_wt_*, addr_rt_wt_* = 0; regWr_en_* = 0; lat_err = collide_err = 0. Reset mid-flight discards all in-flight results. During reset, fw_* equal the rf_* inputs.

Decomposition:
- Shared package holds QUADWORD, REG_ADDR_WIDTH, WB_DEPTH, LAT_WIDTH, and a stage_entry_t struct {valid, addr, data}.
- One sub-module, result_pipe: a single pipe's shift/insert chain with its error flags, instantiated twice.
- Forwarding muxes stay in the top level.

Test Plan:
- Even input, lat=2, addr=5, data=A after reset: regWr_en_even pulses for exactly one cycle, WB_DEPTH-1 = 6 cycles after the input cycle, with addr_rt_wt_even=5 and rt_wt_even=A.
- Odd lat=7 addr=9 data=B: regWr_en_odd pulses on the next cycle. addr_ra_od=9 returns fw_ra_od=B during that write cycle, then returns the rf value.
- Even lat=1 addr=3 data=C, then next cycle odd lat=1 addr=3 data=D: fw_rb_ev returns D (the younger entry), not C, while both are in flight.
- Same-cycle even/odd lat=4 addr=3, data=E/F: fw_rc_ev returns F (odd wins the tie); both write ports fire on the same cycle.
- Even lat=1 in cycle t, then lat=2 in cycle t+1, both valid: collide_err=1, and only the second result is written.
- Input lat=0: no write occurs and lat_err=1. Assert reset with 3 entries in flight: no regWr_en pulses afterwards, and all outputs are 0 while reset is held.

Source files
------------

// File: rtl/writeback_forward_unit_pkg.sv
// rtl/writeback_forward_unit_pkg.sv - shared widths and result-stage types for the writeback forward unit
package writeback_forward_unit_pkg;

  localparam int QUADWORD       = 128;
  localparam int REG_ADDR_WIDTH = 7;
  localparam int WB_DEPTH       = 7;
  localparam int LAT_WIDTH      = 3;

  typedef struct packed {
    logic                      valid;
    logic [REG_ADDR_WIDTH-1:0] addr;
    logic [QUADWORD-1:0]       data;
  } stage_entry_t;

  // Index 1 is the youngest stage, index WB_DEPTH drives the register-file write.
  typedef stage_entry_t [WB_DEPTH:1] stage_vec_t;

endpackage

// File: rtl/writeback_forward_unit_result_pipe.sv
// rtl/writeback_forward_unit_result_pipe.sv - one pipe's result shift chain with latency-targeted insertion
module writeback_forward_unit_result_pipe
  import writeback_forward_unit_pkg::*;
(
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      i_valid,
  input  logic [REG_ADDR_WIDTH-1:0] i_addr,
  input  logic [QUADWORD-1:0]       i_data,
  input  logic [LAT_WIDTH-1:0]      i_lat,
  output stage_vec_t                o_stages,
  output logic                      o_lat_err,
  output logic                      o_collide_err
);

  stage_vec_t r_stage;
  stage_vec_t w_next;
  logic       r_lat_err;
  logic       r_collide_err;
  logic       w_lat_hit;
  logic       w_ins;
  logic       w_collide;

  always_comb begin
    w_lat_hit = 1'b0;
    for (int k = 1; k <= WB_DEPTH; k++) begin
      if (i_lat == LAT_WIDTH'(k)) w_lat_hit = 1'b1;
    end
  end

  assign w_ins = i_valid && w_lat_hit;

  // Shift first, then let the insertion overwrite its target stage so the new result wins.
  always_comb begin
    w_next    = '0;
    w_collide = 1'b0;
    for (int k = 2; k <= WB_DEPTH; k++) begin
      w_next[k] = r_stage[k-1];
      if (w_ins && (i_lat == LAT_WIDTH'(k)) && r_stage[k-1].valid) w_collide = 1'b1;
    end
    for (int k = 1; k <= WB_DEPTH; k++) begin
      if (w_ins && (i_lat == LAT_WIDTH'(k))) begin
        w_next[k].valid = 1'b1;
        w_next[k].addr  = i_addr;
        w_next[k].data  = i_data;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_stage       <= '0;
      r_lat_err     <= 1'b0;
      r_collide_err <= 1'b0;
    end else begin
      r_stage <= w_next;
      if (i_valid && !w_lat_hit) r_lat_err <= 1'b1;
      if (w_collide) r_collide_err <= 1'b1;
    end
  end

  assign o_stages      = r_stage;
  assign o_lat_err     = r_lat_err;
  assign o_collide_err = r_collide_err;

endmodule

// File: rtl/writeback_forward_unit.sv
// rtl/writeback_forward_unit.sv - dual-pipe writeback staging with operand forwarding to five read ports
module writeback_forward_unit
  import writeback_forward_unit_pkg::*;
(
  input  logic                      clk,
  input  logic                      reset,
  input  logic [QUADWORD-1:0]       ev_result,
  input  logic [QUADWORD-1:0]       od_result,
  input  logic [REG_ADDR_WIDTH-1:0] ev_addr,
  input  logic [REG_ADDR_WIDTH-1:0] od_addr,
  input  logic                      ev_valid,
  input  logic                      od_valid,
  input  logic [LAT_WIDTH-1:0]      ev_lat,
  input  logic [LAT_WIDTH-1:0]      od_lat,
  input  logic [QUADWORD-1:0]       rf_ra_ev,
  input  logic [QUADWORD-1:0]       rf_rb_ev,
  input  logic [QUADWORD-1:0]       rf_rc_ev,
  input  logic [QUADWORD-1:0]       rf_ra_od,
  input  logic [QUADWORD-1:0]       rf_rb_od,
  input  logic [REG_ADDR_WIDTH-1:0] addr_ra_ev,
  input  logic [REG_ADDR_WIDTH-1:0] addr_rb_ev,
  input  logic [REG_ADDR_WIDTH-1:0] addr_rc_ev,
  input  logic [REG_ADDR_WIDTH-1:0] addr_ra_od,
  input  logic [REG_ADDR_WIDTH-1:0] addr_rb_od,
  output logic [QUADWORD-1:0]       fw_ra_ev,
  output logic [QUADWORD-1:0]       fw_rb_ev,
  output logic [QUADWORD-1:0]       fw_rc_ev,
  output logic [QUADWORD-1:0]       fw_ra_od,
  output logic [QUADWORD-1:0]       fw_rb_od,
  output logic [QUADWORD-1:0]       rt_wt_even,
  output logic [QUADWORD-1:0]       rt_wt_odd,
  output logic [REG_ADDR_WIDTH-1:0] addr_rt_wt_even,
  output logic [REG_ADDR_WIDTH-1:0] addr_rt_wt_odd,
  output logic                      regWr_en_even,
  output logic                      regWr_en_odd,
  output logic                      lat_err,
  output logic                      collide_err
);

  stage_vec_t w_ev_stage;
  stage_vec_t w_od_stage;
  logic       w_ev_lat_err;
  logic       w_od_lat_err;
  logic       w_ev_collide_err;
  logic       w_od_collide_err;

  writeback_forward_unit_result_pipe u_ev_pipe (
    .clk           (clk),
    .reset         (reset),
    .i_valid       (ev_valid),
    .i_addr        (ev_addr),
    .i_data        (ev_result),
    .i_lat         (ev_lat),
    .o_stages      (w_ev_stage),
    .o_lat_err     (w_ev_lat_err),
    .o_collide_err (w_ev_collide_err)
  );

  writeback_forward_unit_result_pipe u_od_pipe (
    .clk           (clk),
    .reset         (reset),
    .i_valid       (od_valid),
    .i_addr        (od_addr),
    .i_data        (od_result),
    .i_lat         (od_lat),
    .o_stages      (w_od_stage),
    .o_lat_err     (w_od_lat_err),
    .o_collide_err (w_od_collide_err)
  );

  // Walk oldest to youngest so younger stages overwrite; odd is checked after even to win ties.
  function automatic logic [QUADWORD-1:0] fwd_pick(
    input logic [REG_ADDR_WIDTH-1:0] addr,
    input logic [QUADWORD-1:0]       rf,
    input stage_vec_t                ev,
    input stage_vec_t                od
  );
    logic [QUADWORD-1:0] v;
    v = rf;
    for (int k = WB_DEPTH; k >= 1; k--) begin
      if (ev[k].valid && (ev[k].addr == addr)) v = ev[k].data;
      if (od[k].valid && (od[k].addr == addr)) v = od[k].data;
    end
    return v;
  endfunction

  assign fw_ra_ev = fwd_pick(addr_ra_ev, rf_ra_ev, w_ev_stage, w_od_stage);
  assign fw_rb_ev = fwd_pick(addr_rb_ev, rf_rb_ev, w_ev_stage, w_od_stage);
  assign fw_rc_ev = fwd_pick(addr_rc_ev, rf_rc_ev, w_ev_stage, w_od_stage);
  assign fw_ra_od = fwd_pick(addr_ra_od, rf_ra_od, w_ev_stage, w_od_stage);
  assign fw_rb_od = fwd_pick(addr_rb_od, rf_rb_od, w_ev_stage, w_od_stage);

  assign rt_wt_even      = w_ev_stage[WB_DEPTH].data;
  assign addr_rt_wt_even = w_ev_stage[WB_DEPTH].addr;
  assign regWr_en_even   = w_ev_stage[WB_DEPTH].valid;
  assign rt_wt_odd       = w_od_stage[WB_DEPTH].data;
  assign addr_rt_wt_odd  = w_od_stage[WB_DEPTH].addr;
  assign regWr_en_odd    = w_od_stage[WB_DEPTH].valid;

  assign lat_err     = w_ev_lat_err | w_od_lat_err;
  assign collide_err = w_ev_collide_err | w_od_collide_err;

endmodule

// File: tb/tb_writeback_forward_unit.sv
// tb/tb_writeback_forward_unit.sv - directed-vector bench for writeback_forward_unit
module tb_writeback_forward_unit;
  import writeback_forward_unit_pkg::*;

  localparam logic [QUADWORD-1:0] D_A = 128'h0A0A_0000_1111_2222_3333_4444_5555_AAAA;
  localparam logic [QUADWORD-1:0] D_B = 128'h0B0B_0000_6666_7777_8888_9999_AAAA_BBBB;
  localparam logic [QUADWORD-1:0] D_C = 128'h0C0C_0000_0000_0000_0000_0000_0000_000C;
  localparam logic [QUADWORD-1:0] D_D = 128'h0D0D_0000_0000_0000_0000_0000_0000_000D;
  localparam logic [QUADWORD-1:0] D_E = 128'h0E0E_0000_0000_0000_0000_0000_0000_000E;
  localparam logic [QUADWORD-1:0] D_F = 128'h0F0F_0000_0000_0000_0000_0000_0000_000F;
  localparam logic [QUADWORD-1:0] D_G = 128'h1010_0000_0000_0000_0000_0000_0000_0010;
  localparam logic [QUADWORD-1:0] D_H = 128'h1111_0000_0000_0000_0000_0000_0000_0011;
  localparam logic [QUADWORD-1:0] D_I = 128'h1212_0000_0000_0000_0000_0000_0000_0012;
  localparam logic [QUADWORD-1:0] D_X = 128'h1313_0000_0000_0000_0000_0000_0000_0013;
  localparam logic [QUADWORD-1:0] RF_RA_EV = 128'hF000_0000_0000_0000_0000_0000_0000_00A1;
  localparam logic [QUADWORD-1:0] RF_RB_EV = 128'hF000_0000_0000_0000_0000_0000_0000_00B1;
  localparam logic [QUADWORD-1:0] RF_RC_EV = 128'hF000_0000_0000_0000_0000_0000_0000_00C1;
  localparam logic [QUADWORD-1:0] RF_RA_OD = 128'hF000_0000_0000_0000_0000_0000_0000_00A2;
  localparam logic [QUADWORD-1:0] RF_RB_OD = 128'hF000_0000_0000_0000_0000_0000_0000_00B2;
  localparam logic [REG_ADDR_WIDTH-1:0] NO_ADDR = 7'd127;

  logic                      clk = 1'b0;
  logic                      reset;
  logic [QUADWORD-1:0]       ev_result, od_result;
  logic [REG_ADDR_WIDTH-1:0] ev_addr, od_addr;
  logic                      ev_valid, od_valid;
  logic [LAT_WIDTH-1:0]      ev_lat, od_lat;
  logic [QUADWORD-1:0]       rf_ra_ev, rf_rb_ev, rf_rc_ev, rf_ra_od, rf_rb_od;
  logic [REG_ADDR_WIDTH-1:0] addr_ra_ev, addr_rb_ev, addr_rc_ev, addr_ra_od, addr_rb_od;
  logic [QUADWORD-1:0]       fw_ra_ev, fw_rb_ev, fw_rc_ev, fw_ra_od, fw_rb_od;
  logic [QUADWORD-1:0]       rt_wt_even, rt_wt_odd;
  logic [REG_ADDR_WIDTH-1:0] addr_rt_wt_even, addr_rt_wt_odd;
  logic                      regWr_en_even, regWr_en_odd;
  logic                      lat_err, collide_err;

  int checks = 0;
  int errors = 0;

  writeback_forward_unit dut (
    .clk             (clk),
    .reset           (reset),
    .ev_result       (ev_result),
    .od_result       (od_result),
    .ev_addr         (ev_addr),
    .od_addr         (od_addr),
    .ev_valid        (ev_valid),
    .od_valid        (od_valid),
    .ev_lat          (ev_lat),
    .od_lat          (od_lat),
    .rf_ra_ev        (rf_ra_ev),
    .rf_rb_ev        (rf_rb_ev),
    .rf_rc_ev        (rf_rc_ev),
    .rf_ra_od        (rf_ra_od),
    .rf_rb_od        (rf_rb_od),
    .addr_ra_ev      (addr_ra_ev),
    .addr_rb_ev      (addr_rb_ev),
    .addr_rc_ev      (addr_rc_ev),
    .addr_ra_od      (addr_ra_od),
    .addr_rb_od      (addr_rb_od),
    .fw_ra_ev        (fw_ra_ev),
    .fw_rb_ev        (fw_rb_ev),
    .fw_rc_ev        (fw_rc_ev),
    .fw_ra_od        (fw_ra_od),
    .fw_rb_od        (fw_rb_od),
    .rt_wt_even      (rt_wt_even),
    .rt_wt_odd       (rt_wt_odd),
    .addr_rt_wt_even (addr_rt_wt_even),
    .addr_rt_wt_odd  (addr_rt_wt_odd),
    .regWr_en_even   (regWr_en_even),
    .regWr_en_odd    (regWr_en_odd),
    .lat_err         (lat_err),
    .collide_err     (collide_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [QUADWORD-1:0] act, input logic [QUADWORD-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clr_in();
    ev_valid  = 1'b0; od_valid  = 1'b0;
    ev_lat    = '0;   od_lat    = '0;
    ev_addr   = '0;   od_addr   = '0;
    ev_result = '0;   od_result = '0;
  endtask

  task automatic watch(input int n, output int ev_cnt, output int od_cnt,
                       output logic [REG_ADDR_WIDTH-1:0] ev_a, output logic [QUADWORD-1:0] ev_d);
    ev_cnt = 0; od_cnt = 0; ev_a = '0; ev_d = '0;
    for (int i = 0; i < n; i++) begin
      if (regWr_en_even === 1'b1) begin
        ev_cnt++;
        ev_a = addr_rt_wt_even;
        ev_d = rt_wt_even;
      end
      if (regWr_en_odd === 1'b1) od_cnt++;
      step();
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

  initial begin
    int                        n_ev, n_od;
    logic [REG_ADDR_WIDTH-1:0] w_a;
    logic [QUADWORD-1:0]       w_d;

    reset = 1'b1;
    clr_in();
    rf_ra_ev = RF_RA_EV; rf_rb_ev = RF_RB_EV; rf_rc_ev = RF_RC_EV;
    rf_ra_od = RF_RA_OD; rf_rb_od = RF_RB_OD;
    addr_ra_ev = NO_ADDR; addr_rb_ev = NO_ADDR; addr_rc_ev = NO_ADDR;
    addr_ra_od = NO_ADDR; addr_rb_od = NO_ADDR;
    step();
    chk("rst_en_even", QUADWORD'(regWr_en_even), '0);
    chk("rst_en_odd", QUADWORD'(regWr_en_odd), '0);
    chk("rst_wt_even", rt_wt_even, '0);
    chk("rst_addr_odd", QUADWORD'(addr_rt_wt_odd), '0);
    chk("rst_lat_err", QUADWORD'(lat_err), '0);
    chk("rst_collide_err", QUADWORD'(collide_err), '0);
    chk("rst_fw_rb_od", fw_rb_od, RF_RB_OD);
    step();
    reset = 1'b0;
    step();

    // lat=2: write pulse exactly 6 cycles after the input cycle
    ev_valid = 1'b1; ev_lat = 3'd2; ev_addr = 7'd5; ev_result = D_A;
    step();
    clr_in();
    for (int c = 1; c <= 8; c++) begin
      chk($sformatf("lat2_en_c%0d", c), QUADWORD'(regWr_en_even), QUADWORD'(c == 6));
      if (c == 6) begin
        chk("lat2_addr", QUADWORD'(addr_rt_wt_even), QUADWORD'(7'd5));
        chk("lat2_data", rt_wt_even, D_A);
      end
      step();
    end

    // lat=7: odd write on the next cycle, forwarded during the write cycle
    od_valid = 1'b1; od_lat = 3'd7; od_addr = 7'd9; od_result = D_B;
    step();
    clr_in();
    addr_ra_od = 7'd9;
    #1;
    chk("lat7_en_odd", QUADWORD'(regWr_en_odd), QUADWORD'(1'b1));
    chk("lat7_addr_odd", QUADWORD'(addr_rt_wt_odd), QUADWORD'(7'd9));
    chk("lat7_data_odd", rt_wt_odd, D_B);
    chk("lat7_fw_ra_od", fw_ra_od, D_B);
    step();
    chk("lat7_en_odd_after", QUADWORD'(regWr_en_odd), '0);
    chk("lat7_fw_ra_od_after", fw_ra_od, RF_RA_OD);
    addr_ra_od = NO_ADDR;

    // younger odd entry shadows older even entry at the same address
    ev_valid = 1'b1; ev_lat = 3'd1; ev_addr = 7'd3; ev_result = D_C;
    step();
    clr_in();
    od_valid = 1'b1; od_lat = 3'd1; od_addr = 7'd3; od_result = D_D;
    step();
    clr_in();
    addr_rb_ev = 7'd3;
    #1;
    chk("young_fw_rb_ev", fw_rb_ev, D_D);
    step();
    chk("young_fw_rb_ev_2", fw_rb_ev, D_D);
    repeat (8) step();
    chk("young_fw_rb_ev_drained", fw_rb_ev, RF_RB_EV);
    addr_rb_ev = NO_ADDR;

    // same-stage tie: odd wins, both ports write together
    ev_valid = 1'b1; ev_lat = 3'd4; ev_addr = 7'd3; ev_result = D_E;
    od_valid = 1'b1; od_lat = 3'd4; od_addr = 7'd3; od_result = D_F;
    step();
    clr_in();
    addr_rc_ev = 7'd3;
    #1;
    chk("tie_fw_rc_ev", fw_rc_ev, D_F);
    repeat (3) step();
    chk("tie_en_even", QUADWORD'(regWr_en_even), QUADWORD'(1'b1));
    chk("tie_en_odd", QUADWORD'(regWr_en_odd), QUADWORD'(1'b1));
    chk("tie_data_even", rt_wt_even, D_E);
    chk("tie_data_odd", rt_wt_odd, D_F);
    chk("tie_fw_rc_ev_last", fw_rc_ev, D_F);
    step();
    chk("tie_en_even_after", QUADWORD'(regWr_en_even), '0);
    addr_rc_ev = NO_ADDR;

    // collision: lat1 then lat2 targets the stage the first is shifting into
    chk("pre_collide_err", QUADWORD'(collide_err), '0);
    ev_valid = 1'b1; ev_lat = 3'd1; ev_addr = 7'd10; ev_result = D_G;
    step();
    ev_lat = 3'd2; ev_addr = 7'd11; ev_result = D_H;
    step();
    clr_in();
    chk("collide_err", QUADWORD'(collide_err), QUADWORD'(1'b1));
    watch(8, n_ev, n_od, w_a, w_d);
    chk("collide_writes", QUADWORD'(n_ev), QUADWORD'(1));
    chk("collide_addr", QUADWORD'(w_a), QUADWORD'(7'd11));
    chk("collide_data", w_d, D_H);

    // lat=0 is dropped and flagged
    chk("pre_lat_err", QUADWORD'(lat_err), '0);
    ev_valid = 1'b1; ev_lat = 3'd0; ev_addr = 7'd12; ev_result = D_I;
    step();
    clr_in();
    chk("lat0_lat_err", QUADWORD'(lat_err), QUADWORD'(1'b1));
    watch(8, n_ev, n_od, w_a, w_d);
    chk("lat0_no_write", QUADWORD'(n_ev), '0);

    // reset with three entries in flight
    ev_valid = 1'b1; ev_lat = 3'd3; ev_addr = 7'd20; ev_result = D_X;
    step();
    clr_in();
    od_valid = 1'b1; od_lat = 3'd5; od_addr = 7'd21; od_result = D_X;
    step();
    clr_in();
    ev_valid = 1'b1; ev_lat = 3'd6; ev_addr = 7'd22; ev_result = D_X;
    step();
    clr_in();
    addr_ra_ev = 7'd20;
    #1;
    chk("inflight_fw_ra_ev", fw_ra_ev, D_X);
    #2;
    reset = 1'b1;
    #1;
    chk("mid_rst_en_even", QUADWORD'(regWr_en_even), '0);
    chk("mid_rst_en_odd", QUADWORD'(regWr_en_odd), '0);
    chk("mid_rst_wt_even", rt_wt_even, '0);
    chk("mid_rst_wt_odd", rt_wt_odd, '0);
    chk("mid_rst_addr_even", QUADWORD'(addr_rt_wt_even), '0);
    chk("mid_rst_lat_err", QUADWORD'(lat_err), '0);
    chk("mid_rst_collide_err", QUADWORD'(collide_err), '0);
    chk("mid_rst_fw_ra_ev", fw_ra_ev, RF_RA_EV);
    step();
    chk("held_rst_en_even", QUADWORD'(regWr_en_even), '0);
    reset = 1'b0;
    watch(10, n_ev, n_od, w_a, w_d);
    chk("post_rst_ev_writes", QUADWORD'(n_ev), '0);
    chk("post_rst_od_writes", QUADWORD'(n_od), '0);
    addr_ra_ev = NO_ADDR;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
